// File: rtl/counter_sched_if.sv
// rtl/counter_sched_if.sv - requester/counter bundle shared by counter_sched and its peers
//
// Purpose: groups the request/grant handshake and the shared-counter control
// lines of the round-robin counter scheduler into one interface.
//
// Signals:
//   req      requester -> sched  NREQ     level request per requester
//   tgt      requester -> sched  NREQ*CW  target count, requester i at [i*CW +: CW]
//   cnt_val  counter   -> sched  CW       current value of the shared counter
//   cnt_clr  sched -> counter    1        synchronous clear, active high
//   cnt_en   sched -> counter    1        count enable
//   gnt      sched -> requester  NREQ     one-hot grant, zero when idle
//   done     sched -> requester  NREQ     one-cycle completion pulse
//   busy     sched -> requester  1        scheduler is not idle
//
// Modports: master = requesters plus counter (environment side),
//           slave  = the scheduler itself.

interface counter_sched_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] tgt;
  logic [CW-1:0]      cnt_val;
  logic               cnt_clr;
  logic               cnt_en;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;

  modport master (
    output req, tgt, cnt_val,
    input  cnt_clr, cnt_en, gnt, done, busy
  );

  modport slave (
    input  req, tgt, cnt_val,
    output cnt_clr, cnt_en, gnt, done, busy
  );
endinterface

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one up-counter among NREQ requesters
//
// Purpose: grants the shared counter to one requester at a time, clears it,
// enables it until the owner's latched target is reached, then pulses the
// owner's done. Requests are served round-robin starting after the last owner.
//
// Ports:
//   clk   input   rising-edge clock
//   rst   input   asynchronous active-low reset
//   bus   slave   counter_sched_if: req/tgt/cnt_val in, cnt_clr/cnt_en/gnt/done/busy out

module counter_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  counter_sched_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [IW-1:0]             owner, owner_nxt;
  logic [IW-1:0]             last, last_nxt;
  logic [CW-1:0]             tgt_q, tgt_nxt;

  logic [NREQ-1:0][CW-1:0]   tgt_arr;
  logic                      pick_valid;
  logic [IW-1:0]             pick;
  logic                      owner_req;
  logic                      at_tgt;

  assign tgt_arr   = bus.tgt;
  assign owner_req = bus.req[owner];
  assign at_tgt    = (bus.cnt_val == tgt_q);

  // Round-robin search: first active request strictly after the last owner,
  // wrapping, so the previous owner is always considered last.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!pick_valid && bus.req[idx[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[IW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      tgt_q <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      tgt_q <= tgt_nxt;
    end
  end

  // Next-state logic. Dropping the owner's request before DONE abandons the
  // run without a done pulse, but still advances the round-robin pointer so
  // the aborting requester does not keep top priority.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    tgt_nxt   = tgt_q;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = CLEAR;
          owner_nxt = pick;
          tgt_nxt   = tgt_arr[pick];
        end
      end
      CLEAR: begin
        if (!owner_req) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!owner_req) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else if (at_tgt) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        last_nxt  = owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. cnt_en drops in the same cycle the counter shows the
  // target, so the counter stops exactly at tgt_q and never wraps.
  always_comb begin
    bus.cnt_clr = 1'b0;
    bus.cnt_en  = 1'b0;
    bus.gnt     = '0;
    bus.done    = '0;
    bus.busy    = 1'b0;
    case (state)
      CLEAR: begin
        bus.cnt_clr    = 1'b1;
        bus.gnt[owner] = 1'b1;
        bus.busy       = 1'b1;
      end
      RUN: begin
        bus.cnt_en     = !at_tgt;
        bus.gnt[owner] = 1'b1;
        bus.busy       = 1'b1;
      end
      DONE: begin
        bus.done[owner] = 1'b1;
        bus.gnt[owner]  = 1'b1;
        bus.busy        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - self-checking bench for counter_sched

module tb_counter_sched;
  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

  counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared up-counter: synchronous clear, count enable, free to wrap.
  logic [CW-1:0] counter = '0;
  always @(posedge clk) begin
    if (bus.cnt_clr)     counter <= '0;
    else if (bus.cnt_en) counter <= counter + 1'b1;
  end
  assign bus.cnt_val = counter;

  int n_assert = 0;
  int n_fail   = 0;
  int last_m   = NREQ - 1;
  int pend_m   = 0;
  int tgt_m [NREQ];
  int first_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int i, input int t);
    bus.tgt[i*CW +: CW] = CW'(t);
    bus.req[i] = 1'b1;
    tgt_m[i]   = t;
    pend_m     = pend_m | (1 << i);
  endtask

  // Round-robin reference: first pending requester after the last owner.
  function automatic int rr_pick(input int mask, input int lst);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (lst + k) % NREQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  // Follows one complete grant and checks it against the expected run shape:
  // tgt+3 cycles, one clear cycle first, tgt enable cycles, done in the last
  // cycle with the counter sitting at tgt.
  task automatic grant_check(input int owner, input int t, input int gap);
    int waited, len, clr, en, dn, dn_at, val_done;
    logic [NREQ-1:0] oh;
    waited = 0; len = 0; clr = 0; en = 0; dn = 0; dn_at = 0; val_done = -1;
    oh = NREQ'(1) << owner;
    tick();
    while (bus.gnt == '0 && waited < 60) begin
      waited++;
      tick();
    end
    if (gap >= 0) check("idle_gap", waited, gap);
    check("grant_owner", bus.gnt, oh);
    first_val = int'(bus.cnt_val);
    while (bus.gnt != '0 && len < 300) begin
      len++;
      check("gnt_stable", bus.gnt, oh);
      check("busy_in_grant", bus.busy, 1);
      if (bus.cnt_clr) begin
        clr++;
        check("clr_first_cycle", len, 1);
      end
      if (bus.cnt_en) en++;
      if (bus.done != '0) begin
        dn++;
        dn_at    = len;
        val_done = int'(bus.cnt_val);
        check("done_owner", bus.done, oh);
        bus.req[owner] = 1'b0;
        pend_m = pend_m & ~(1 << owner);
      end
      // Target changes after the grant must not affect the current run.
      if (len == 2) bus.tgt[owner*CW +: CW] = CW'($urandom);
      tick();
    end
    check("grant_len", len, t + 3);
    check("clr_cycles", clr, 1);
    check("en_cycles", en, t);
    check("done_pulses", dn, 1);
    check("done_position", dn_at, t + 3);
    check("val_at_done", val_done, t);
    check("idle_busy", bus.busy, 0);
    check("idle_en", bus.cnt_en, 0);
    last_m = owner;
  endtask

  task automatic serve_all(input int gap, input bit rand_arrive);
    int g, rounds;
    g = gap;
    rounds = 0;
    while (pend_m != 0 && rounds < 40) begin
      int o;
      o = rr_pick(pend_m, last_m);
      grant_check(o, tgt_m[o], g);
      g = 0;
      rounds++;
      if (rand_arrive && $urandom_range(0, 2) == 0) begin
        int i;
        i = int'($urandom_range(0, NREQ - 1));
        if (!pend_m[i]) request(i, int'($urandom_range(0, (1 << CW) - 1)));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_m = NREQ - 1;
  endtask

  initial begin
    int w;
    bus.req = '0;
    bus.tgt = '0;

    // Reset with every requester asking.
    rst = 1'b0;
    bus.req = '1;
    repeat (2) tick();
    check("rst_gnt", bus.gnt, 0);
    check("rst_en", bus.cnt_en, 0);
    check("rst_clr", bus.cnt_clr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b1;
    last_m = NREQ - 1;

    // Single run to 5.
    request(0, 5);
    serve_all(0, 1'b0);

    // Round robin from reset: order 0,1,2,3 twice.
    do_reset();
    for (int i = 0; i < NREQ; i++) request(i, i + 1);
    serve_all(-1, 1'b0);
    for (int i = 0; i < NREQ; i++) request(i, i + 1);
    serve_all(0, 1'b0);

    // Zero target.
    request(2, 0);
    serve_all(0, 1'b0);

    // Max target: stops at 15 and holds.
    request(1, (1 << CW) - 1);
    serve_all(0, 1'b0);
    repeat (3) tick();
    check("no_wrap", bus.cnt_val, (1 << CW) - 1);

    // Abort in RUN with a request pending behind it.
    request(1, 10);
    w = 0;
    tick();
    while (bus.gnt == '0 && w < 20) begin w++; tick(); end
    check("abort_grant", bus.gnt, 4'b0010);
    request(3, 7);
    w = 0;
    while (!(bus.cnt_val == 3 && !bus.cnt_clr) && w < 30) begin w++; tick(); end
    check("abort_en_before", bus.cnt_en, 1);
    bus.req[1] = 1'b0;
    pend_m = pend_m & ~(1 << 1);
    last_m = 1;
    tick();
    check("abort_gnt", bus.gnt, 0);
    check("abort_done", bus.done, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_val", bus.cnt_val, 4);
    grant_check(3, 7, 0);
    check("abort_val_held", first_val, 4);

    // Asynchronous reset mid-run.
    request(0, 9);
    w = 0;
    while (!(bus.cnt_val == 3 && !bus.cnt_clr) && w < 30) begin w++; tick(); end
    check("arst_running", bus.gnt, 4'b0001);
    #2;
    rst = 1'b0;
    #1;
    check("arst_gnt", bus.gnt, 0);
    check("arst_en", bus.cnt_en, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_clr", bus.cnt_clr, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("arst_no_done", bus.done, 0);
    end
    check("arst_val_held", bus.cnt_val, 3);
    request(2, 2);
    request(1, 1);
    @(negedge clk);
    rst = 1'b1;
    last_m = NREQ - 1;
    serve_all(0, 1'b0);

    // Random request sets with random later arrivals.
    for (int r = 0; r < 12; r++) begin
      int mask;
      mask = int'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        if (mask[i]) request(i, int'($urandom_range(0, (1 << CW) - 1)));
      serve_all(0, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
